// File: rtl/image_loader.sv
// Pixel-stream front end for neural_network: scales 8-bit pixels to 0..127, fills a 28x28 frame
// buffer, runs the network and returns its digit. Optional noise threshold: IMAGE_LOADER_THRESH_EN.
module image_loader #(
  parameter int NUM_PIXELS  = 784,
  parameter int PIXEL_W     = 8,
  parameter int RUN_TIMEOUT = 65535,
  parameter int THRESH      = 16
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 pixel_valid,
  output logic                                 pixel_ready,
  input  logic [PIXEL_W-1:0]                   pixel_data,
  input  logic                                 frame_sync,
  output logic [NUM_PIXELS-1:0][PIXEL_W-1:0]   imagine,
  output logic                                 enable,
  input  logic                                 stare_retea,
  input  logic [7:0]                           cifra_iesire,
  output logic [7:0]                           digit,
  output logic                                 digit_valid,
  output logic                                 timeout_err,
  output logic                                 busy
);

  localparam int INDEX_W = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
  localparam int TIMER_W = $clog2(RUN_TIMEOUT + 1);
  localparam logic [INDEX_W-1:0] LAST_INDEX = INDEX_W'(NUM_PIXELS - 1);
  localparam logic [TIMER_W-1:0] LAST_TICK  = TIMER_W'(RUN_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_ARM,
    ST_RUN
  } state_e;

  state_e                             state_q, state_d;
  logic [INDEX_W-1:0]                 index_q, index_d;
  logic [TIMER_W-1:0]                 timer_q, timer_d;
  logic [NUM_PIXELS-1:0][PIXEL_W-1:0] imagine_q, imagine_d;
  logic                               enable_q, enable_d;
  logic [7:0]                         digit_q, digit_d;
  logic                               digit_valid_q, digit_valid_d;
  logic                               timeout_err_q, timeout_err_d;
  logic                               stare_prev_q, stare_prev_d;

  logic [PIXEL_W-1:0] scaled;
  logic [PIXEL_W-1:0] pixel_store;
  logic [INDEX_W-1:0] wr_idx;
  logic               transfer;
  logic               stare_edge;
  logic               unused_pixel_lsb;

  assign unused_pixel_lsb = pixel_data[0];
  assign scaled           = {1'b0, pixel_data[PIXEL_W-1:1]};

`ifdef IMAGE_LOADER_THRESH_EN
  assign pixel_store = (scaled < PIXEL_W'(THRESH)) ? '0 : scaled;
`else
  localparam int unused_thresh = THRESH;
  assign pixel_store = scaled;
`endif

  assign pixel_ready = (state_q == ST_LOAD);
  assign busy        = (state_q == ST_ARM) || (state_q == ST_RUN);
  assign transfer    = pixel_valid && pixel_ready;
  // History is tracked every cycle, so a level already high on RUN entry is not an edge.
  assign stare_edge  = stare_retea && !stare_prev_q;

  always_comb begin
    state_d       = state_q;
    index_d       = index_q;
    timer_d       = timer_q;
    imagine_d     = imagine_q;
    enable_d      = enable_q;
    digit_d       = digit_q;
    digit_valid_d = 1'b0;
    timeout_err_d = 1'b0;
    stare_prev_d  = stare_retea;
    wr_idx        = frame_sync ? '0 : index_q;

    case (state_q)
      ST_LOAD: begin
        if (transfer) begin
          imagine_d[wr_idx] = pixel_store;
          if (wr_idx == LAST_INDEX) begin
            index_d = '0;
            state_d = ST_ARM;
          end else begin
            index_d = wr_idx + INDEX_W'(1);
          end
        end else if (frame_sync) begin
          index_d = '0;
        end
      end
      ST_ARM: begin
        enable_d = 1'b1;
        timer_d  = '0;
        state_d  = ST_RUN;
      end
      ST_RUN: begin
        timer_d = timer_q + TIMER_W'(1);
        // A completion edge takes priority over a coincident timeout.
        if (stare_edge) begin
          digit_d       = cifra_iesire;
          digit_valid_d = 1'b1;
          enable_d      = 1'b0;
          state_d       = ST_LOAD;
        end else if (timer_q == LAST_TICK) begin
          timeout_err_d = 1'b1;
          enable_d      = 1'b0;
          state_d       = ST_LOAD;
        end
      end
      default: begin
        state_d  = ST_LOAD;
        enable_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= ST_LOAD;
      index_q       <= '0;
      timer_q       <= '0;
      imagine_q     <= '0;
      enable_q      <= 1'b0;
      digit_q       <= '0;
      digit_valid_q <= 1'b0;
      timeout_err_q <= 1'b0;
      stare_prev_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      index_q       <= index_d;
      timer_q       <= timer_d;
      imagine_q     <= imagine_d;
      enable_q      <= enable_d;
      digit_q       <= digit_d;
      digit_valid_q <= digit_valid_d;
      timeout_err_q <= timeout_err_d;
      stare_prev_q  <= stare_prev_d;
    end
  end

  assign imagine     = imagine_q;
  assign enable      = enable_q;
  assign digit       = digit_q;
  assign digit_valid = digit_valid_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_image_loader.sv
// Randomized bench for image_loader: a frame-level model tracks what the buffer and result ports must hold.
module tb_image_loader;

  localparam int NUM_PIXELS  = 784;
  localparam int PIXEL_W     = 8;
  localparam int RUN_TIMEOUT = 32;
  localparam int THRESH      = 16;

  logic                               clock = 1'b0;
  logic                               reset = 1'b0;
  logic                               pixel_valid = 1'b0;
  logic                               frame_sync = 1'b0;
  logic                               stare_retea = 1'b0;
  logic [PIXEL_W-1:0]                 pixel_data = '0;
  logic [7:0]                         cifra_iesire = '0;
  logic                               pixel_ready, enable, digit_valid, timeout_err, busy;
  logic [7:0]                         digit;
  logic [NUM_PIXELS-1:0][PIXEL_W-1:0] imagine;

  int checks = 0;
  int errors = 0;
  int exp_img [NUM_PIXELS];
  int exp_idx;
  int exp_digit;

  image_loader #(
    .NUM_PIXELS (NUM_PIXELS),
    .PIXEL_W    (PIXEL_W),
    .RUN_TIMEOUT(RUN_TIMEOUT),
    .THRESH     (THRESH)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .pixel_valid (pixel_valid),
    .pixel_ready (pixel_ready),
    .pixel_data  (pixel_data),
    .frame_sync  (frame_sync),
    .imagine     (imagine),
    .enable      (enable),
    .stare_retea (stare_retea),
    .cifra_iesire(cifra_iesire),
    .digit       (digit),
    .digit_valid (digit_valid),
    .timeout_err (timeout_err),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input longint obs, input longint expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  function automatic int scale(input int p);
    int s;
    s = p / 2;
`ifdef IMAGE_LOADER_THRESH_EN
    if (s < THRESH) s = 0;
`endif
    return s;
  endfunction

  task automatic clear_model;
    for (int i = 0; i < NUM_PIXELS; i++) exp_img[i] = 0;
    exp_idx   = 0;
    exp_digit = 0;
  endtask

  task automatic do_reset;
    reset       = 1'b0;
    pixel_valid = 1'b0;
    frame_sync  = 1'b0;
    tick;
    reset = 1'b1;
    clear_model;
  endtask

  task automatic send(input int p, input bit sync);
    int n;
    repeat ($urandom_range(0, 2)) tick;
    pixel_valid = 1'b1;
    pixel_data  = PIXEL_W'(p);
    frame_sync  = sync;
    n = 0;
    while (!pixel_ready && n < 50) begin
      tick;
      n++;
    end
    if (!pixel_ready) check("ready_wait", pixel_ready, 1);
    tick;
    pixel_valid = 1'b0;
    frame_sync  = 1'b0;
    if (sync) exp_idx = 0;
    exp_img[exp_idx] = scale(p);
    exp_idx++;
    if (exp_idx == NUM_PIXELS) exp_idx = 0;
  endtask

  task automatic send_random(input int count);
    for (int i = 0; i < count; i++) send(int'($urandom_range(0, 255)), 1'b0);
  endtask

  task automatic check_image(input string tag);
    for (int i = 0; i < NUM_PIXELS; i++)
      check($sformatf("%s[%0d]", tag, i), imagine[i], exp_img[i]);
  endtask

  task automatic wait_enable;
    int n;
    n = 0;
    while (!enable && n < 10) begin
      tick;
      n++;
    end
    check("enable_rise", enable, 1);
  endtask

  initial begin
    int cnt;
    int pulses;
    logic [7:0] d;

    // Reset state
    do_reset;
    check("rst_ready", pixel_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_enable", enable, 0);
    check("rst_digit", digit, 0);
    check("rst_dvalid", digit_valid, 0);
    check("rst_tmo", timeout_err, 0);
    check("rst_img0", imagine[0], 0);
    check("rst_img783", imagine[783], 0);

    // Directed frame: 255 then 2, followed by a normal completion
    for (int i = 0; i < NUM_PIXELS; i++) begin
      if (i == NUM_PIXELS - 1) check("ready_before_last", pixel_ready, 1);
      send((i < NUM_PIXELS / 2) ? 255 : 2, 1'b0);
    end
    check("arm_ready", pixel_ready, 0);
    check("arm_busy", busy, 1);
    check("arm_enable", enable, 0);
    tick;
    check("run_enable", enable, 1);
    check("run_busy", busy, 1);
    check("img0_127", imagine[0], 127);
    check("img783_1", imagine[783], 1);
    check_image("frame_a");
    stare_retea  = 1'b1;
    cifra_iesire = 8'd6;
    tick;
    exp_digit = 6;
    check("done_dvalid", digit_valid, 1);
    check("done_digit", digit, exp_digit);
    check("done_enable", enable, 0);
    check("done_ready", pixel_ready, 1);
    check("done_tmo", timeout_err, 0);
    tick;
    check("dvalid_one_cycle", digit_valid, 0);
    stare_retea = 1'b0;

    // stare_retea held high through RUN entry must not complete the run
    stare_retea = 1'b1;
    send_random(NUM_PIXELS);
    wait_enable;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      if (digit_valid) pulses++;
      tick;
    end
    check("held_no_pulse", pulses, 0);
    check("held_still_run", enable, 1);
    check_image("frame_b");
    stare_retea = 1'b0;
    tick;
    d = 8'($urandom_range(0, 9));
    stare_retea  = 1'b1;
    cifra_iesire = d;
    tick;
    exp_digit = d;
    check("reedge_dvalid", digit_valid, 1);
    check("reedge_digit", digit, exp_digit);
    stare_retea = 1'b0;

    // Timeout with stare_retea held high: digit must keep its old value
    stare_retea = 1'b1;
    send_random(NUM_PIXELS);
    cifra_iesire = 8'd200;
    wait_enable;
    cnt = 0;
    while (enable && !timeout_err && cnt < 200) begin
      cnt++;
      tick;
    end
    check("tmo_cycles", cnt, RUN_TIMEOUT);
    check("tmo_pulse", timeout_err, 1);
    check("tmo_enable", enable, 0);
    check("tmo_ready", pixel_ready, 1);
    check("tmo_digit", digit, exp_digit);
    check("tmo_dvalid", digit_valid, 0);
    tick;
    check("tmo_one_cycle", timeout_err, 0);
    stare_retea = 1'b0;

    // Edge arriving on the timeout cycle wins
    send_random(NUM_PIXELS);
    wait_enable;
    repeat (RUN_TIMEOUT - 1) tick;
    check("late_enable", enable, 1);
    check("late_no_tmo", timeout_err, 0);
    d = 8'($urandom_range(0, 255));
    stare_retea  = 1'b1;
    cifra_iesire = d;
    tick;
    exp_digit = d;
    check("tie_dvalid", digit_valid, 1);
    check("tie_tmo", timeout_err, 0);
    check("tie_digit", digit, exp_digit);
    tick;
    check("tie_tmo_after", timeout_err, 0);
    stare_retea = 1'b0;

    // frame_sync alone keeps the buffer, frame_sync with a pixel restarts at index 0
    send_random(60);
    cnt = exp_img[30];
    frame_sync = 1'b1;
    tick;
    frame_sync = 1'b0;
    exp_idx = 0;
    check("sync_keeps_img30", imagine[30], cnt);
    check("sync_ready", pixel_ready, 1);
    send_random(100);
    send(200, 1'b1);
    check("sync_img0", imagine[0], 100);
    send_random(NUM_PIXELS - 2);
    check("sync_not_armed", busy, 0);
    check("sync_ready_783", pixel_ready, 1);
    send_random(1);
    check("sync_armed", busy, 1);
    check_image("frame_sync");

    // Reset in RUN discards everything
    wait_enable;
    reset = 1'b0;
    tick;
    reset = 1'b1;
    clear_model;
    check("mid_rst_enable", enable, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", pixel_ready, 1);
    check("mid_rst_digit", digit, 0);
    check_image("mid_rst");

    // Noise threshold behaviour
    send(30, 1'b0);
    send(31, 1'b0);
    send(32, 1'b0);
`ifdef IMAGE_LOADER_THRESH_EN
    check("thr_30", imagine[0], 0);
    check("thr_31", imagine[1], 0);
`else
    check("thr_30", imagine[0], 15);
    check("thr_31", imagine[1], 15);
`endif
    check("thr_32", imagine[2], 16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
